// File: rtl/uart_response_parser_pkg.sv
// Shared constants, state types and line-classification helpers for the modem response parser.
// The LF terminator matches the one the command transmitter appends.
package uart_response_parser_pkg;

    localparam logic [1:0] RESP_TIMEOUT = 2'b00;
    localparam logic [1:0] RESP_OK      = 2'b01;
    localparam logic [1:0] RESP_ERROR   = 2'b10;
    localparam logic [1:0] RESP_OTHER   = 2'b11;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_COLLECT, L_REPORT} line_state_t;

    // Expected character of "OK" at a given position; zero past the end of the pattern
    function automatic logic [7:0] ok_char(input logic [5:0] idx);
        case (idx)
            6'd0:    return 8'h4F;
            6'd1:    return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] err_char(input logic [5:0] idx);
        case (idx)
            6'd0:    return 8'h45;
            6'd1:    return 8'h52;
            6'd2:    return 8'h52;
            6'd3:    return 8'h4F;
            6'd4:    return 8'h52;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] classify(input logic ok_m, input logic er_m,
                                            input logic [5:0] len, input logic ovf,
                                            input logic fe);
        if (ok_m && (len == 6'd2) && !ovf && !fe) begin
            return RESP_OK;
        end else if (er_m && (len == 6'd5) && !ovf && !fe) begin
            return RESP_ERROR;
        end else begin
            return RESP_OTHER;
        end
    endfunction

endpackage

// File: rtl/uart_response_parser_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling, LSB-first shift register.
// Emits a one-cycle byte_valid on a good stop bit, or a one-cycle frame_err on a low stop bit.
module uart_rx
    import uart_response_parser_pkg::*;
#(
    parameter int BAUD = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BAUD - 1);

    rx_state_t      state_r, state_n;
    logic [CW-1:0]  cnt_r, cnt_n;
    logic [2:0]     bit_r, bit_n;
    logic [7:0]     shift_r, shift_n;
    logic           rx_meta_r, rx_sync_r;
    logic           byte_valid_r, byte_valid_n;
    logic           frame_err_r, frame_err_n;

    // Bring the asynchronous line into the clk domain; idle level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Bit-timing state machine: start confirmation at half a bit, then one sample per bit
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r + CW'(1);
        bit_n        = bit_r;
        shift_n      = shift_r;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state_r)
            R_IDLE: begin
                cnt_n = {CW{1'b0}};
                if (!rx_sync_r) begin
                    state_n = R_START;
                end else begin
                    state_n = R_IDLE;
                end
            end
            R_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_n = {CW{1'b0}};
                    bit_n = 3'd0;
                    if (rx_sync_r) begin
                        state_n = R_IDLE;
                    end else begin
                        state_n = R_DATA;
                    end
                end else begin
                    state_n = R_START;
                end
            end
            R_DATA: begin
                if (cnt_r == CNT_BIT) begin
                    cnt_n   = {CW{1'b0}};
                    shift_n = {rx_sync_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_n = R_STOP;
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    state_n = R_DATA;
                end
            end
            R_STOP: begin
                if (cnt_r == CNT_BIT) begin
                    cnt_n   = {CW{1'b0}};
                    state_n = R_IDLE;
                    if (rx_sync_r) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    state_n = R_STOP;
                end
            end
            default: begin
                state_n = R_IDLE;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // Receiver state and output pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= R_IDLE;
            cnt_r        <= {CW{1'b0}};
            bit_r        <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            bit_r        <= bit_n;
            shift_r      <= shift_n;
            byte_valid_r <= byte_valid_n;
            frame_err_r  <= frame_err_n;
        end
    end

    assign data_byte  = shift_r;
    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/uart_response_parser.sv
// Modem reply parser: assembles LF-terminated lines from the UART, classifies them as OK/ERROR/OTHER
// on the fly without buffering, and reports a TIMEOUT when armed and no line arrives in time.
module uart_response_parser
    import uart_response_parser_pkg::*;
#(
    parameter int BAUD        = 434,
    parameter int MAX_LINE    = 32,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       arm,
    output logic       resp_valid,
    output logic [1:0] resp_code,
    output logic [5:0] line_len,
    output logic       frame_err,
    output logic       armed
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LOAD  = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : {TW{1'b0}};
    localparam logic          T_EN    = (TIMEOUT_CYC != 0);
    localparam logic [5:0]    LEN_MAX = 6'(MAX_LINE);

    logic [7:0]  rx_byte_s;
    logic        rx_valid_s;
    logic        rx_fe_s;

    line_state_t state_r, state_n;
    logic [5:0]  cnt_r, cnt_n;
    logic        ok_r, ok_n;
    logic        er_r, er_n;
    logic        ovf_r, ovf_n;
    logic        fe_r, fe_n;
    logic        line_done_s;
    logic [1:0]  class_s;

    logic [TW-1:0] tcnt_r;
    logic          armed_r;
    logic          arm_eff_s;
    logic          fire_s;

    logic          resp_valid_r;
    logic [1:0]    resp_code_r;
    logic [5:0]    line_len_r;

    uart_rx #(.BAUD(BAUD)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_byte  (rx_byte_s),
        .byte_valid (rx_valid_s),
        .frame_err  (rx_fe_s)
    );

    // Line assembly and incremental pattern matching; the char index is the count before increment
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        ok_n        = ok_r;
        er_n        = er_r;
        ovf_n       = ovf_r;
        fe_n        = fe_r;
        line_done_s = 1'b0;
        class_s     = RESP_OTHER;
        case (state_r)
            L_IDLE, L_COLLECT: begin
                if (rx_valid_s) begin
                    if (rx_byte_s == CHAR_CR) begin
                        state_n = state_r;
                    end else if (rx_byte_s == CHAR_LF) begin
                        if (cnt_r != 6'd0) begin
                            line_done_s = 1'b1;
                            class_s     = classify(ok_r, er_r, cnt_r, ovf_r, fe_r);
                            state_n     = L_REPORT;
                        end else begin
                            state_n = L_IDLE;
                        end
                    end else begin
                        state_n = L_COLLECT;
                        ok_n    = ok_r && (cnt_r < 6'd2) && (rx_byte_s == ok_char(cnt_r));
                        er_n    = er_r && (cnt_r < 6'd5) && (rx_byte_s == err_char(cnt_r));
                        if (cnt_r == LEN_MAX) begin
                            ovf_n = 1'b1;
                        end else begin
                            cnt_n = cnt_r + 6'd1;
                        end
                    end
                end else if (rx_fe_s && (cnt_r != 6'd0)) begin
                    fe_n = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            L_REPORT: begin
                state_n = L_IDLE;
                cnt_n   = 6'd0;
                ok_n    = 1'b1;
                er_n    = 1'b1;
                ovf_n   = 1'b0;
                fe_n    = 1'b0;
            end
            default: begin
                state_n = L_IDLE;
                cnt_n   = 6'd0;
                ok_n    = 1'b1;
                er_n    = 1'b1;
                ovf_n   = 1'b0;
                fe_n    = 1'b0;
            end
        endcase
    end

    // Line state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= L_IDLE;
            cnt_r   <= 6'd0;
            ok_r    <= 1'b1;
            er_r    <= 1'b1;
            ovf_r   <= 1'b0;
            fe_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ok_r    <= ok_n;
            er_r    <= er_n;
            ovf_r   <= ovf_n;
            fe_r    <= fe_n;
        end
    end

    // A line report or a fresh arm in the same cycle both suppress the timeout
    assign arm_eff_s = arm && T_EN;
    assign fire_s    = armed_r && (tcnt_r == {TW{1'b0}}) && !line_done_s && !arm_eff_s;

    // Response timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b0;
            tcnt_r  <= {TW{1'b0}};
        end else if (arm_eff_s) begin
            armed_r <= 1'b1;
            tcnt_r  <= T_LOAD;
        end else if (line_done_s || fire_s) begin
            armed_r <= 1'b0;
        end else if (armed_r) begin
            tcnt_r <= tcnt_r - TW'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // Registered report outputs; code and length hold until the next report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_code_r  <= RESP_TIMEOUT;
            line_len_r   <= 6'd0;
        end else begin
            resp_valid_r <= line_done_s || fire_s;
            if (line_done_s) begin
                resp_code_r <= class_s;
                line_len_r  <= cnt_r;
            end else if (fire_s) begin
                resp_code_r <= RESP_TIMEOUT;
                line_len_r  <= 6'd0;
            end else begin
                resp_code_r <= resp_code_r;
                line_len_r  <= line_len_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_code  = resp_code_r;
    assign line_len   = line_len_r;
    assign frame_err  = rx_fe_s;
    assign armed      = armed_r;

endmodule

// File: tb/tb_uart_response_parser.sv
// Directed bench for uart_response_parser: serial lines in, reports captured by a monitor queue
// and compared against hand-computed codes, lengths and timing.
module tb_uart_response_parser;

    localparam int BAUD = 16;
    localparam int TMO  = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       arm = 1'b0;
    logic       resp_valid;
    logic [1:0] resp_code;
    logic [5:0] line_len;
    logic       frame_err;
    logic       armed;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int stop_cyc = 0;
    int arm_cyc  = 0;

    typedef struct {
        logic [1:0] code;
        logic [5:0] len;
        int         cyc;
    } resp_t;
    resp_t rq[$];

    uart_response_parser #(.BAUD(BAUD), .MAX_LINE(32), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .arm        (arm),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .line_len   (line_len),
        .frame_err  (frame_err),
        .armed      (armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every report and frame-error pulse away from the active edge
    always @(negedge clk) begin
        if (resp_valid) rq.push_back('{resp_code, line_len, cyc});
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BAUD);
        end
        stop_cyc = cyc;
        if (good_stop) begin
            rx = 1'b1;
            tick(BAUD);
        end else begin
            rx = 1'b0;
            tick(BAUD * 3 / 4);
            rx = 1'b1;
            tick(BAUD * 2);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic expect_resp(input string tag, input logic [1:0] code, input logic [5:0] len);
        resp_t r;
        tick(4);
        check_eq({tag, "_present"}, 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
            r = rq.pop_front();
            check_eq({tag, "_code"}, 32'(r.code), 32'(code));
            check_eq({tag, "_len"}, 32'(r.len), 32'(len));
        end
    endtask

    task automatic expect_none(input string tag);
        tick(4);
        check_eq(tag, 32'(rq.size()), 32'd0);
    endtask

    initial begin
        tick(5);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_code", 32'(resp_code), 32'd0);
        check_eq("rst_len", 32'(line_len), 32'd0);
        check_eq("rst_fe", 32'(frame_err), 32'd0);
        check_eq("rst_armed", 32'(armed), 32'd0);
        rst = 1'b1;
        tick(2 * BAUD);

        // 1) OK line, reported shortly after the mid-stop-bit sample of the LF
        send_str("OK\r\n");
        tick(2);
        check_eq("t1_latency", 32'((rq.size() != 0) && (rq[0].cyc - stop_cyc >= BAUD / 2)
                                   && (rq[0].cyc - stop_cyc <= BAUD)), 32'd1);
        expect_resp("t1_ok", 2'b01, 6'd2);
        expect_none("t1_single");

        // 2) leading blank line is silent
        send_str("\r\nERROR\r\n");
        expect_resp("t2_error", 2'b10, 6'd5);
        expect_none("t2_single");

        // 3) prefix matches that fail on length
        send_str("OKAY\r\n");
        send_str("ERR\r\n");
        expect_resp("t3_okay", 2'b11, 6'd4);
        expect_resp("t3_err", 2'b11, 6'd3);
        expect_none("t3_extra");

        // 4) overlong line saturates, then state is clean
        for (int i = 0; i < 40; i++) send_byte(8'h41, 1'b1);
        send_byte(8'h0A, 1'b1);
        expect_resp("t4_long", 2'b11, 6'd32);
        send_str("OK\r\n");
        expect_resp("t4_after", 2'b01, 6'd2);

        // 5) timeout fires TMO clocks after the edge that samples arm
        arm = 1'b1;
        arm_cyc = cyc;
        tick(1);
        arm = 1'b0;
        check_eq("t5_armed", 32'(armed), 32'd1);
        for (int i = 0; (i < TMO + 100) && (rq.size() == 0); i++) tick(1);
        check_eq("t5_delay", (rq.size() != 0) ? 32'(rq[0].cyc - arm_cyc) : 32'hFFFF_FFFF,
                 32'(TMO + 1));
        expect_resp("t5_tmo", 2'b00, 6'd0);
        check_eq("t5_disarmed", 32'(armed), 32'd0);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        send_str("OK\r\n");
        expect_resp("t5_ok", 2'b01, 6'd2);
        check_eq("t5_ok_disarms", 32'(armed), 32'd0);
        tick(TMO + 100);
        expect_none("t5_no_late_tmo");

        // 6) framing errors: outside a line, then inside a line
        send_byte(8'h4F, 1'b0);
        check_eq("t6_fe_count", 32'(fe_cnt), 32'd1);
        send_str("K\r\n");
        expect_resp("t6_k", 2'b11, 6'd1);
        send_str("OK");
        send_byte(8'h58, 1'b0);
        send_str("\n");
        check_eq("t6_fe_count2", 32'(fe_cnt), 32'd2);
        expect_resp("t6_fe_line", 2'b11, 6'd2);

        // reset in the middle of a byte with a partial line pending and armed
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        send_str("OK");
        rx = 1'b0;
        tick(BAUD);
        rx = 1'b1;
        tick(BAUD);
        rx = 1'b0;
        tick(BAUD / 2);
        rst = 1'b0;
        tick(2);
        check_eq("t6_rst_valid", 32'(resp_valid), 32'd0);
        check_eq("t6_rst_code", 32'(resp_code), 32'd0);
        check_eq("t6_rst_len", 32'(line_len), 32'd0);
        check_eq("t6_rst_fe", 32'(frame_err), 32'd0);
        check_eq("t6_rst_armed", 32'(armed), 32'd0);
        tick(8 * BAUD);
        rx = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2 * BAUD);
        expect_none("t6_rst_silent");
        send_str("OK\r\n");
        expect_resp("t6_after_rst", 2'b01, 6'd2);
        expect_none("t6_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
